register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port CPU register file: N_RD async read ports, N_WR write ports, write-to-read bypass,
//  per-register busy scoreboard for pending writebacks, and a post-reset clear sweep suited to RAM inference.
//  Sits between decode (read/claim) and writeback in the CPU32 pipeline; register 0 is hardwired to zero.
// PARAMETERS
//  XLEN    32  data word width
//  N_REGS  32  number of architectural registers (power of 2, >=2); ADR_W = $clog2(N_REGS)
//  N_RD    3   number of read ports
//  N_WR    2   number of write ports
// PORTS
//  clk_cpu     in   1           CPU clock; all state updates on rising edge
//  reset       in   1           synchronous, active-high reset
//  ready       out  1           1 = clear sweep finished, ports operational
//  rd_adrs     in   N_RD*ADR_W  read addresses, port p at [p*ADR_W +: ADR_W]
//  q           out  N_RD*XLEN   read data, port p at [p*XLEN +: XLEN]
//  rd_busy     out  N_RD        1 = register on port p awaits a writeback not yet available
//  wr_en       in   N_WR        per-port write enable
//  wr_adrs     in   N_WR*ADR_W  write addresses
//  wr_data     in   N_WR*XLEN   write data
//  claim_en    in   1           mark claim_adrs busy (instruction issued with that destination)
//  claim_adrs  in   ADR_W       destination being claimed
// BEHAVIOUR
//  Reset (reset=1 at edge): state<=CLEAR, sweep ptr<=0, all busy<=0, ready<=0; overrides everything, also mid-RUN.
//  CLEAR: each cycle regs[ptr]<=0, ptr<=ptr+1; at ptr==N_REGS-1 state<=RUN, ready<=1 same edge.
//   -> ready rises exactly N_REGS edges after the first edge with reset=0. wr_en/claim_en ignored in CLEAR.
//   q = 0 and rd_busy = 0 on all ports while ready=0.
//  RUN writes: port w commits regs[adrs]<=data when wr_en[w] & adrs!=0; adrs 0 silently dropped.
//   Same address on several write ports in one cycle: highest-index port wins.
//  RUN reads (combinational, zero latency):
//   adrs==0 -> q=0, rd_busy=0.
//   else if any enabled write port targets adrs this cycle -> q=that wr_data (highest index wins), rd_busy=0 (bypass).
//   else q=regs[adrs], rd_busy=busy[adrs].
//  Scoreboard (RUN, next-edge update per register r!=0):
//   set when claim_en & claim_adrs==r; clear when some wr_en[w] & wr_adrs[w]==r.
//   set and clear same cycle on r -> busy[r]=1 (claim is the newer producer). busy[0] never set.
//   Claim on an already-busy register: stays 1 (no counting; one outstanding writer per reg).
//  No width conversion: data passes unmodified; ptr is ADR_W bits, wraps never reached (stops at N_REGS-1).
//  Output reset values: ready=0, q=0, rd_busy=0.
// STRUCTURE
//  Package regfile_pkg: XLEN/N_REGS/N_RD/N_WR defaults, ADR_W function, typedef enum logic {CLEAR, RUN} rf_state_t,
//   typedef logic [XLEN-1:0] word_t.
//  Sub-module rf_read_port (one instance per read port, generate loop): zero-reg check, write-bypass priority
//   mux across N_WR ports, busy masking. Top holds storage array, scoreboard vector, CLEAR/RUN FSM and sweep ptr.
//  Storage must have no reset term (cleared only by sweep) so it maps to distributed RAM.
// TESTING
//  1 Reset 1 cycle then release; count edges -> ready=0 for 31 edges, 1 after 32nd; all q=0 before/after.
//  2 RUN: wr0 r5<=0xDEADBEEF, next cycle read r5 on all 3 ports -> q=0xDEADBEEF, rd_busy=0; write r0<=1 -> r0 reads 0.
//  3 Same cycle: wr0 r7<=0x11, wr1 r7<=0x22, read port0 r7 -> q=0x22 combinationally; next cycle regs r7=0x22.
//  4 claim r9; next cycle read r9 -> rd_busy=1; wr0 r9<=0x55 that cycle -> q=0x55, rd_busy=0; cycle after busy=0.
//  5 claim r3 and wr1 r3<=0x1 same cycle -> next cycle q=0x1, rd_busy=1 on r3.
//  6 Write r4<=0xAA, claim r6, assert reset mid-RUN -> ready=0, after sweep r4 reads 0, r6 rd_busy=0; writes during CLEAR lost.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared types and default sizing for the multi-port CPU register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int RF_XLEN   = 32;
  localparam int RF_N_REGS = 32;
  localparam int RF_N_RD   = 3;
  localparam int RF_N_WR   = 2;

  // Address width for a register count; never below one bit.
  function automatic int adr_w(input int n_regs);
    return (n_regs <= 2) ? 1 : $clog2(n_regs);
  endfunction

  typedef enum logic {CLEAR, RUN} rf_state_t;

  typedef logic [RF_XLEN-1:0] word_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback bundle of the register file: read, write and claim ports plus ready.
// Latency: reads are combinational; writes and claims land on the next clk_cpu edge.
// Backpressure: none; consumers must hold off until ready is high.
interface register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int N_REGS = 32,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  parameter int ADR_W  = $clog2(N_REGS)
);

  logic                  ready;
  logic [N_RD*ADR_W-1:0] rd_adrs;
  logic [N_RD*XLEN-1:0]  q;
  logic [N_RD-1:0]       rd_busy;
  logic [N_WR-1:0]       wr_en;
  logic [N_WR*ADR_W-1:0] wr_adrs;
  logic [N_WR*XLEN-1:0]  wr_data;
  logic                  claim_en;
  logic [ADR_W-1:0]      claim_adrs;

  // Pipeline side: issues addresses, writebacks and claims.
  modport master (
    input  ready, q, rd_busy,
    output rd_adrs, wr_en, wr_adrs, wr_data, claim_en, claim_adrs
  );

  // Register file side.
  modport slave (
    output ready, q, rd_busy,
    input  rd_adrs, wr_en, wr_adrs, wr_data, claim_en, claim_adrs
  );

endinterface

// File: rtl/register_file_mp_rd_port.sv
// One read port: zero-register check, same-cycle write bypass, busy masking.
// Latency: combinational.
// Backpressure: none; outputs forced to zero while the file is not running.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int N_WR  = RF_N_WR,
  parameter int ADR_W = 5
) (
  input  logic                  run_i,
  input  logic [ADR_W-1:0]      adrs_i,
  input  logic [XLEN-1:0]       reg_dat_i,
  input  logic                  reg_busy_i,
  input  logic [N_WR-1:0]       wr_en_i,
  input  logic [N_WR*ADR_W-1:0] wr_adrs_i,
  input  logic [N_WR*XLEN-1:0]  wr_data_i,
  output logic [XLEN-1:0]       q_o,
  output logic                  busy_o
);

  // Stored value first, then let each matching write port override in
  // ascending order so the highest-index writer is what the reader sees.
  // A bypassed value is by definition available, so busy drops.
  always_comb begin
    q_o    = '0;
    busy_o = 1'b0;
    if (run_i && (adrs_i != '0)) begin
      q_o    = reg_dat_i;
      busy_o = reg_busy_i;
      for (int w = 0; w < N_WR; w++) begin
        if (wr_en_i[w] && (wr_adrs_i[w*ADR_W +: ADR_W] == adrs_i)) begin
          q_o    = wr_data_i[w*XLEN +: XLEN];
          busy_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write bypass, busy scoreboard and post-reset clear sweep.
// Latency: reads combinational; writes/claims visible after one clk_cpu edge; ready N_REGS edges after reset.
// Backpressure: ready low during the sweep; writes and claims are dropped until it rises.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int N_REGS = RF_N_REGS,
  parameter int N_RD   = RF_N_RD,
  parameter int N_WR   = RF_N_WR
) (
  input  logic              clk_cpu,
  input  logic              reset,
  register_file_mp_if.slave bus
);

  localparam int ADR_W = adr_w(N_REGS);

  rf_state_t         state_q, state_d;
  logic [ADR_W-1:0]  ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic [N_REGS-1:0] busy_q, busy_d;
  logic [N_REGS-1:0] wr_hit;
  logic [XLEN-1:0]   regs_q [N_REGS];

  // Control state: reset wins over everything, including a running file.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Registers targeted by any enabled write port this cycle.
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < N_WR; w++) begin
      if (bus.wr_en[w]) begin
        wr_hit[bus.wr_adrs[w*ADR_W +: ADR_W]] = 1'b1;
      end
    end
  end

  // Sweep sequencing and scoreboard next state; a claim beats a same-cycle
  // writeback because the claiming instruction is the newer producer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == ADR_W'(N_REGS - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        for (int r = 1; r < N_REGS; r++) begin
          busy_d[r] = (busy_q[r] & ~wr_hit[r]) |
                      (bus.claim_en && (bus.claim_adrs == ADR_W'(r)));
        end
        busy_d[0] = 1'b0;
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Storage has no reset term so it stays RAM-friendly; the sweep zeroes it.
  // Ascending port order leaves the highest-index writer's data in place.
  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        regs_q[ptr_q] <= '0;
      end else begin
        for (int w = 0; w < N_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_adrs[w*ADR_W +: ADR_W] != '0)) begin
            regs_q[bus.wr_adrs[w*ADR_W +: ADR_W]] <= bus.wr_data[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign bus.ready = ready_q;

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [ADR_W-1:0] adrs;
    logic [XLEN-1:0]  q_p;
    logic             busy_p;

    assign adrs = bus.rd_adrs[p*ADR_W +: ADR_W];

    rf_read_port #(
      .XLEN (XLEN),
      .N_WR (N_WR),
      .ADR_W(ADR_W)
    ) u_rd (
      .run_i     (ready_q),
      .adrs_i    (adrs),
      .reg_dat_i (regs_q[adrs]),
      .reg_busy_i(busy_q[adrs]),
      .wr_en_i   (bus.wr_en),
      .wr_adrs_i (bus.wr_adrs),
      .wr_data_i (bus.wr_data),
      .q_o       (q_p),
      .busy_o    (busy_p)
    );

    assign bus.q[p*XLEN +: XLEN] = q_p;
    assign bus.rd_busy[p]        = busy_p;
  end

endmodule
